// File: rtl/line_pixel_stepper.sv
// Bresenham pixel stepper: takes pre-ordered line setup values and emits one
// screen-space pixel per accepted handshake, then pulses done for a cycle.
module line_pixel_stepper #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] deltax,
  input  logic [WIDTH-1:0] deltay,
  input  logic [WIDTH-1:0] ystep,
  input  logic             steep,
  output logic [WIDTH-1:0] px_x,
  output logic [WIDTH-1:0] px_y,
  output logic             px_valid,
  input  logic             px_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0]        x1_q, x1_d, dx_q, dx_d, dy_q, dy_d, ystep_q, ystep_d;
  logic                    steep_q, steep_d;
  logic signed [WIDTH:0]   err_q, err_d;
  logic                    in_ready_q, in_ready_d, px_valid_q, px_valid_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]        px_x_q, px_x_d, px_y_q, px_y_d;

  // One extra bit on err keeps err - deltay and e + deltax in range.
  logic signed [WIDTH:0]   dx_ext, dy_ext, err_init, e_sum;
  logic [WIDTH-1:0]        one;

  assign dx_ext   = $signed({dx_q[WIDTH-1], dx_q});
  assign dy_ext   = $signed({dy_q[WIDTH-1], dy_q});
  assign err_init = $signed({deltax[WIDTH-1], deltax}) >>> 1;
  assign e_sum    = err_q - dy_ext;
  assign one      = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x1_d    = x1_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    ystep_d = ystep_q;
    steep_d = steep_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x0;
          y_d     = y0;
          x1_d    = x1;
          dx_d    = deltax;
          dy_d    = deltay;
          ystep_d = ystep;
          steep_d = steep;
          err_d   = err_init;
          state_d = RUN;
        end
      end
      RUN: begin
        if (px_ready) begin
          if (x_q == x1_q) begin
            state_d = DONE;
          end else begin
            x_d = x_q + one;
            if (e_sum[WIDTH]) begin
              y_d   = y_q + ystep_q;
              err_d = e_sum + dx_ext;
            end else begin
              err_d = e_sum;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they come straight off flops.
    in_ready_d = (state_d == IDLE);
    px_valid_d = (state_d == RUN);
    done_d     = (state_d == DONE);
    busy_d     = (state_d != IDLE);
    px_x_d     = steep_d ? y_d : x_d;
    px_y_d     = steep_d ? x_d : y_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      x1_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      ystep_q    <= '0;
      steep_q    <= 1'b0;
      err_q      <= '0;
      in_ready_q <= 1'b1;
      px_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      px_x_q     <= '0;
      px_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x1_q       <= x1_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      ystep_q    <= ystep_d;
      steep_q    <= steep_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      px_valid_q <= px_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
    end
  end

  assign in_ready = in_ready_q;
  assign px_valid = px_valid_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign px_x     = px_x_q;
  assign px_y     = px_y_q;

endmodule

// File: tb/tb_line_pixel_stepper.sv
// Bench for line_pixel_stepper: directed and random lines against a closed-form
// Bresenham model, with stalls, mid-line reset and ignored setup requests.
module tb_line_pixel_stepper;
  localparam int W    = 13;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         steep = 1'b0;
  logic         px_ready = 1'b0;
  logic [W-1:0] x0 = '0, x1 = '0, y0 = '0, deltax = '0, deltay = '0, ystep = '0;
  logic         in_ready, px_valid, busy, done;
  logic [W-1:0] px_x, px_y;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_x[$];
  int exp_y[$];
  int line_no = 0;

  line_pixel_stepper #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .y0(y0), .deltax(deltax), .deltay(deltay), .ystep(ystep),
    .steep(steep), .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
    .px_ready(px_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (line %0d, t=%0t)", tag, got, want, line_no, $time);
    end
  endtask

  // Pixel i of a line steps y by k_i = ceil((i*dy - floor(dx/2)) / dx), floored at 0.
  task automatic build(input int ax0, input int adx, input int ay0, input int ady,
                       input int ys, input bit st);
    int k, px, py;
    exp_x.delete();
    exp_y.delete();
    for (int i = 0; i <= adx; i++) begin
      k  = (adx == 0) ? 0 : (i * ady - adx / 2 + adx - 1) / adx;
      px = (ax0 + i) & MASK;
      py = (ay0 + ys * k) & MASK;
      exp_x.push_back(st ? py : px);
      exp_y.push_back(st ? px : py);
    end
  endtask

  // Called in the negedge region; the transfer happens on the next rising edge.
  task automatic setup(input int ax0, input int adx, input int ay0, input int ady,
                       input int ys, input bit st);
    line_no++;
    check("setup_in_ready", int'(in_ready), 1);
    x0       = W'(ax0);
    x1       = W'(ax0 + adx);
    y0       = W'(ay0);
    deltax   = W'(adx);
    deltay   = W'(ady);
    ystep    = W'(ys);
    steep    = st;
    in_valid = 1'b1;
    build(ax0, adx, ay0, ady, ys, st);
    $display("line %0d: x0=%0d dx=%0d y0=%0d dy=%0d ystep=%0d steep=%0d pixels=%0d",
             line_no, ax0, adx, ay0, ady, ys, st, exp_x.size());
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_line(input bit stall, input bit junk, input int abort_at);
    int idx = 0;
    int cycles = 0;
    int n = exp_x.size();
    while (idx < n) begin
      @(negedge clk);
      cycles++;
      if (cycles > 8 * n + 50) begin
        check("timeout_pixels", idx, n);
        break;
      end
      check("px_valid", int'(px_valid), 1);
      check("done_in_run", int'(done), 0);
      check("busy_in_run", int'(busy), 1);
      check("px_x", int'(px_x), exp_x[idx]);
      check("px_y", int'(px_y), exp_y[idx]);
      if (idx == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_px_valid", int'(px_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_px_x", int'(px_x), 0);
        check("rst_px_y", int'(px_y), 0);
        return;
      end
      if (junk) begin
        check("in_ready_in_run", int'(in_ready), 0);
        in_valid = 1'b1;
        x0       = W'($urandom);
        x1       = W'($urandom);
        y0       = W'($urandom);
        deltax   = W'($urandom);
        deltay   = W'($urandom);
        ystep    = W'($urandom);
        steep    = 1'($urandom);
      end
      px_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (px_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("done_pulse", int'(done), 1);
    check("done_px_valid", int'(px_valid), 0);
    check("done_busy", int'(busy), 1);
    px_ready = 1'($urandom);
    @(negedge clk);
    check("done_cleared", int'(done), 0);
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_busy", int'(busy), 0);
    check("idle_px_valid", int'(px_valid), 0);
  endtask

  initial begin
    int dx, dy, ax0, ys;
    bit st;

    #2 rst = 1'b1;
    #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_px_valid", int'(px_valid), 0);
    check("reset_done", int'(done), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_px_x", int'(px_x), 0);
    check("reset_px_y", int'(px_y), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    @(negedge clk); setup(0, 4, 0, 2, 1, 1'b0);  run_line(1'b0, 1'b0, -1);
    @(negedge clk); setup(0, 2, 5, 2, -1, 1'b1); run_line(1'b0, 1'b0, -1);
    @(negedge clk); setup(7, 0, 3, 0, 1, 1'b0);  run_line(1'b0, 1'b0, -1);
    @(negedge clk); setup(0, 4, 0, 2, 1, 1'b0);  run_line(1'b1, 1'b0, -1);

    // Reset on the third pixel; the line must be abandoned silently.
    @(negedge clk); setup(0, 4, 0, 2, 1, 1'b0);  run_line(1'b0, 1'b0, 2);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
      check("abort_px_valid", int'(px_valid), 0);
    end
    rst = 1'b0;
    setup(0, 4, 0, 2, 1, 1'b0);                  run_line(1'b0, 1'b0, -1);

    @(negedge clk); setup(0, 4, 0, 2, 1, 1'b0);  run_line(1'b0, 1'b1, -1);
    @(negedge clk); setup(-20, 9, 100, 5, -1, 1'b1); run_line(1'b1, 1'b1, -1);

    // Near-full-range slope exercises the extra error bit and coordinate wrap.
    @(negedge clk);
    setup(-4096, 4095, int'($urandom_range(0, MASK)), int'($urandom_range(3000, 4095)), 1, 1'b0);
    run_line(1'b0, 1'b0, -1);

    for (int t = 0; t < 25; t++) begin
      dx  = int'($urandom_range(0, 24));
      dy  = int'($urandom_range(0, dx));
      ax0 = int'($urandom_range(0, MASK - dx)) - 4096;
      ys  = ($urandom_range(0, 1) != 0) ? 1 : -1;
      st  = 1'($urandom);
      @(negedge clk);
      setup(ax0, dx, int'($urandom_range(0, MASK)), dy, ys, st);
      run_line(1'($urandom), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
